// File: rtl/writeback.sv
// writeback: WB stage with load formatting, write-back mux, forwarding copy, halt FSM and event counters
module writeback #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     ALU_out_MEMWB,
  input  logic [WIDTH-1:0]     pc_4_MEMWB,
  input  logic [WIDTH-1:0]     mem_rd_data_MEMWB,
  input  logic [1:0]           reg_wr_ctrl_MEMWB,
  input  logic [2:0]           funct3_MEMWB,
  input  logic [1:0]           byte_offset_MEMWB,
  input  logic [4:0]           rd_MEMWB,
  input  logic                 reg_wr_en_MEMWB,
  input  logic                 halt_WB,
  output logic [WIDTH-1:0]     reg_wr_data_WBID,
  output logic [4:0]           rd_WBID,
  output logic                 reg_wr_en_WBID,
  output logic                 fwd_valid_q,
  output logic [4:0]           fwd_rd_q,
  output logic [WIDTH-1:0]     fwd_data_q,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] wb_count
);
  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;
  state_t                 state_q, state_d;
  logic [7:0]             byte_sel;
  logic [15:0]            half_sel;
  logic [WIDTH-1:0]       load_data;
  logic                   we;
  logic                   fwd_valid_d;
  logic [4:0]             fwd_rd_d;
  logic [WIDTH-1:0]       fwd_data_d;
  logic [CNT_WIDTH-1:0]   cycle_count_q, cycle_count_d, wb_count_q, wb_count_d;
  // Align the loaded byte/half and extend it according to the load type
  always_comb begin
    byte_sel  = mem_rd_data_MEMWB[{byte_offset_MEMWB, 3'b000} +: 8];
    half_sel  = mem_rd_data_MEMWB[{byte_offset_MEMWB[1], 4'b0000} +: 16];
    load_data = funct3_MEMWB == 3'b000 ? {{(WIDTH-8){byte_sel[7]}}, byte_sel} :
                funct3_MEMWB == 3'b100 ? {{(WIDTH-8){1'b0}}, byte_sel} :
                funct3_MEMWB == 3'b001 ? {{(WIDTH-16){half_sel[15]}}, half_sel} :
                funct3_MEMWB == 3'b101 ? {{(WIDTH-16){1'b0}}, half_sel} :
                mem_rd_data_MEMWB;
    reg_wr_data_WBID = reg_wr_ctrl_MEMWB == 2'd0 ? ALU_out_MEMWB :
                       reg_wr_ctrl_MEMWB == 2'd1 ? pc_4_MEMWB :
                       reg_wr_ctrl_MEMWB == 2'd2 ? load_data : '0;
    rd_WBID          = rd_MEMWB;
  end
  // Halt FSM next state: HALTED only leaves through reset
  always_comb begin
    state_d = (state_q == RUN && halt_WB) ? HALTED : state_q;
  end
  // FSM outputs: write qualification (halt instruction and reset never write) and halted flag
  always_comb begin
    we             = reg_wr_en_MEMWB && rd_MEMWB != 5'd0 && state_q == RUN && !halt_WB && !reset;
    reg_wr_en_WBID = we;
    halted         = state_q == HALTED;
  end
  // Counter and forwarding next values
  always_comb begin
    cycle_count_d = state_q == RUN ? cycle_count_q + CNT_WIDTH'(1) : cycle_count_q;
    wb_count_d    = we ? wb_count_q + CNT_WIDTH'(1) : wb_count_q;
    fwd_valid_d   = we;
    fwd_rd_d      = we ? rd_MEMWB : fwd_rd_q;
    fwd_data_d    = we ? reg_wr_data_WBID : fwd_data_q;
  end
  // State register; reset dominates a same-cycle halt
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      cycle_count_q <= '0;
      wb_count_q    <= '0;
      fwd_valid_q   <= 1'b0;
      fwd_rd_q      <= '0;
      fwd_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      cycle_count_q <= cycle_count_d;
      wb_count_q    <= wb_count_d;
      fwd_valid_q   <= fwd_valid_d;
      fwd_rd_q      <= fwd_rd_d;
      fwd_data_q    <= fwd_data_d;
    end
  end
  assign cycle_count = cycle_count_q;
  assign wb_count    = wb_count_q;
endmodule

// File: tb/tb_writeback.sv
// tb_writeback: randomized and directed checks of writeback against a behavioural model
module tb_writeback;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu, pc4, md;
  logic [1:0]  ctrl, off;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic        en, halt;
  logic [31:0] wr_data, fwd_data;
  logic [4:0]  wr_rd, fwd_rd;
  logic        wr_en, fwd_valid, halted;
  logic [63:0] cycle_count, wb_count;
  int          total = 0;
  int          bad = 0;
  logic        m_halted, m_fv;
  logic [63:0] m_cyc, m_wb;
  logic [4:0]  m_frd;
  logic [31:0] m_fd;

  writeback dut (
    .clk(clk), .reset(reset),
    .ALU_out_MEMWB(alu), .pc_4_MEMWB(pc4), .mem_rd_data_MEMWB(md),
    .reg_wr_ctrl_MEMWB(ctrl), .funct3_MEMWB(f3), .byte_offset_MEMWB(off),
    .rd_MEMWB(rd), .reg_wr_en_MEMWB(en), .halt_WB(halt),
    .reg_wr_data_WBID(wr_data), .rd_WBID(wr_rd), .reg_wr_en_WBID(wr_en),
    .fwd_valid_q(fwd_valid), .fwd_rd_q(fwd_rd), .fwd_data_q(fwd_data),
    .halted(halted), .cycle_count(cycle_count), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_data(input logic [1:0] c, input logic [2:0] f,
                                           input logic [1:0] o, input logic [31:0] a, p, m);
    int unsigned b, h;
    b = (m / (32'd1 << (8 * int'(o)))) % 256;
    h = (m / (32'd1 << (16 * (int'(o) / 2)))) % 65536;
    if (c == 2'd0) return a;
    if (c == 2'd1) return p;
    if (c == 2'd3) return 32'd0;
    case (f)
      3'd0:    return b >= 128 ? b - 256 : b;
      3'd1:    return h >= 32768 ? h - 65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return m;
    endcase
  endfunction

  function automatic logic model_we();
    return en && rd != 5'd0 && !m_halted && !halt && !reset;
  endfunction

  task automatic tick();
    logic [31:0] d;
    logic        w;
    d = ref_data(ctrl, f3, off, alu, pc4, md);
    w = model_we();
    @(posedge clk);
    if (reset) begin
      m_halted = 0; m_cyc = 0; m_wb = 0; m_fv = 0; m_frd = 0; m_fd = 0;
    end else begin
      if (!m_halted) m_cyc = m_cyc + 1;
      if (w) begin m_wb = m_wb + 1; m_frd = rd; m_fd = d; end
      m_fv = w;
      if (halt) m_halted = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1; halt = 1; en = 1; rd = 5'd7; ctrl = 2'd0; alu = 32'hDEAD_BEEF;
    pc4 = 0; md = 0; f3 = 0; off = 0;
    #1;
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rst_we got %0b want 0", wr_en); end
    total++; if (wr_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rst_data got %h want deadbeef", wr_data); end
    tick();
    reset = 0; halt = 0; en = 0;
    total++; if (halted !== 1'b0 || cycle_count !== 64'd0 || wb_count !== 64'd0)
      begin bad++; $display("FAIL rst_state got h=%0b c=%0d w=%0d want 0 0 0", halted, cycle_count, wb_count); end
    total++; if (fwd_valid !== 1'b0 || fwd_rd !== 5'd0 || fwd_data !== 32'd0)
      begin bad++; $display("FAIL rst_fwd got %0b %0d %h want 0", fwd_valid, fwd_rd, fwd_data); end
  endtask

  task automatic test_load_format();
    logic [2:0]  tf [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [1:0]  to [5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1};
    logic [31:0] tm [5] = '{32'h80FF_1234, 32'h80FF_1234, 32'h8001_7FFF, 32'h8001_7FFF, 32'h8001_7FFF};
    logic [31:0] te [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_7FFF, 32'h8001_7FFF};
    ctrl = 2'd2; en = 0;
    for (int i = 0; i < 5; i++) begin
      f3 = tf[i]; off = to[i]; md = tm[i];
      #1;
      total++; if (wr_data !== te[i]) begin bad++; $display("FAIL load_%0d got %h want %h", i, wr_data, te[i]); end
      tick();
    end
  endtask

  task automatic test_rd_zero();
    ctrl = 2'd0; alu = 32'h1234; rd = 5'd0; en = 1;
    #1;
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rd0_we got %0b want 0", wr_en); end
    tick();
    total++; if (wb_count !== m_wb) begin bad++; $display("FAIL rd0_wbcnt got %0d want %0d", wb_count, m_wb); end
    total++; if (fwd_valid !== 1'b0) begin bad++; $display("FAIL rd0_fv got %0b want 0", fwd_valid); end
    en = 0;
  endtask

  task automatic test_pc_link();
    logic [63:0] wb0;
    wb0 = m_wb;
    ctrl = 2'd1; pc4 = 32'h104; rd = 5'd5; en = 1;
    #1;
    total++; if (wr_data !== 32'h104 || wr_en !== 1'b1 || wr_rd !== 5'd5)
      begin bad++; $display("FAIL link_comb got %h %0b %0d want 104 1 5", wr_data, wr_en, wr_rd); end
    tick();
    en = 0;
    total++; if (fwd_valid !== 1'b1 || fwd_rd !== 5'd5 || fwd_data !== 32'h104)
      begin bad++; $display("FAIL link_fwd got %0b %0d %h want 1 5 104", fwd_valid, fwd_rd, fwd_data); end
    total++; if (wb_count !== wb0 + 1) begin bad++; $display("FAIL link_wbcnt got %0d want %0d", wb_count, wb0 + 1); end
  endtask

  task automatic test_random();
    logic [31:0] ed;
    for (int i = 0; i < 300; i++) begin
      alu = $urandom; pc4 = $urandom; md = $urandom;
      ctrl = 2'($urandom_range(0, 3)); f3 = 3'($urandom_range(0, 7)); off = 2'($urandom_range(0, 3));
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      en = 1'($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 39) == 0);
      #1;
      ed = ref_data(ctrl, f3, off, alu, pc4, md);
      total++; if (wr_data !== ed || wr_rd !== rd)
        begin bad++; $display("FAIL rnd_data[%0d] got %h/%0d want %h/%0d", i, wr_data, wr_rd, ed, rd); end
      total++; if (wr_en !== model_we()) begin bad++; $display("FAIL rnd_we[%0d] got %0b want %0b", i, wr_en, model_we()); end
      tick();
      total++; if (fwd_valid !== m_fv || fwd_rd !== m_frd || fwd_data !== m_fd)
        begin bad++; $display("FAIL rnd_fwd[%0d] got %0b %0d %h want %0b %0d %h", i, fwd_valid, fwd_rd, fwd_data, m_fv, m_frd, m_fd); end
      total++; if (cycle_count !== m_cyc || wb_count !== m_wb || halted !== m_halted)
        begin bad++; $display("FAIL rnd_cnt[%0d] got %0d %0d %0b want %0d %0d %0b", i, cycle_count, wb_count, halted, m_cyc, m_wb, m_halted); end
    end
    reset = 0; en = 0;
  endtask

  task automatic test_halt();
    logic [63:0] wb0;
    reset = 1; tick(); reset = 0;
    en = 0;
    for (int i = 0; i < 10; i++) tick();
    wb0 = m_wb;
    halt = 1; en = 1; rd = 5'd3; ctrl = 2'd0; alu = 32'h55;
    #1;
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL halt_we got %0b want 0", wr_en); end
    tick();
    halt = 0; rd = 5'd4;
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag got %0b want 1", halted); end
    total++; if (cycle_count !== 64'd11) begin bad++; $display("FAIL halt_cyc got %0d want 11", cycle_count); end
    total++; if (wb_count !== wb0 || fwd_valid !== 1'b0)
      begin bad++; $display("FAIL halt_nowr got %0d %0b want %0d 0", wb_count, fwd_valid, wb0); end
    for (int i = 0; i < 5; i++) begin
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL halted_we[%0d] got %0b want 0", i, wr_en); end
      tick();
    end
    total++; if (cycle_count !== 64'd11 || halted !== 1'b1 || wb_count !== wb0)
      begin bad++; $display("FAIL halt_frozen got %0d %0b %0d want 11 1 %0d", cycle_count, halted, wb_count, wb0); end
  endtask

  task automatic test_reset_from_halt();
    reset = 1; en = 1; rd = 5'd9; halt = 1;
    tick();
    reset = 0; halt = 0;
    total++; if (halted !== 1'b0 || cycle_count !== 64'd0 || wb_count !== 64'd0)
      begin bad++; $display("FAIL rh_state got %0b %0d %0d want 0 0 0", halted, cycle_count, wb_count); end
    total++; if (fwd_valid !== 1'b0 || fwd_rd !== 5'd0 || fwd_data !== 32'd0)
      begin bad++; $display("FAIL rh_fwd got %0b %0d %h want 0", fwd_valid, fwd_rd, fwd_data); end
    #1;
    total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL rh_run_we got %0b want 1", wr_en); end
    tick();
    en = 0;
    total++; if (cycle_count !== 64'd1 || wb_count !== 64'd1 || fwd_rd !== 5'd9)
      begin bad++; $display("FAIL rh_run got %0d %0d %0d want 1 1 9", cycle_count, wb_count, fwd_rd); end
  endtask

  initial begin
    test_reset();
    test_load_format();
    test_rd_zero();
    test_pc_link();
    test_random();
    test_halt();
    test_reset_from_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
